uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth = 2^DEPTH_LOG2 bytes (legal range 1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert and active-low.
REQ-004 SHALL have port in_data  input  8  byte offered by the producer.
REQ-005 SHALL have port in_valid  input  1  producer offers in_data this cycle.
REQ-006 SHALL have port in_ready  output  1  FIFO accepts in_data this cycle.
REQ-007 SHALL have port flush  input  1  synchronous clear of all stored bytes and the overflow flag.
REQ-008 SHALL have port out_data  output  8  head byte, drives the transmitter write_data.
REQ-009 SHALL have port out_req  output  1  head byte valid, drives the transmitter write_req.
REQ-010 SHALL have port out_ready  input  1  transmitter idle, driven from the transmitter ready.
REQ-011 SHALL have port count  output  DEPTH_LOG2+1  number of stored bytes.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port full  output  1  count == 2^DEPTH_LOG2.
REQ-014 SHALL have port overflow  output  1  sticky flag, a byte was offered while full.

Function
REQ-015 SHALL implement a circular buffer with read and write pointers of DEPTH_LOG2 bits that wrap modulo 2^DEPTH_LOG2, plus count of DEPTH_LOG2+1 bits.
REQ-016 SHALL drive in_ready = !full && !flush, combinationally.
REQ-017 SHALL push (write mem[wr_ptr], increment wr_ptr) on a cycle with in_valid && in_ready.
REQ-018 SHALL drive out_req = !empty && !flush, combinationally from registered count.
REQ-019 SHALL drive out_data = mem[rd_ptr]; value is don't-care while out_req = 0.
REQ-020 SHALL pop (increment rd_ptr) on a cycle with out_req && out_ready; the transmitter latches out_data in that same cycle.
REQ-021 SHALL make a pushed byte visible on out_req/out_data no earlier than the cycle after the push; there is no same-cycle fall-through when empty.
REQ-022 SHALL, on a cycle with both push and pop, keep count unchanged and advance both pointers.
REQ-023 SHALL otherwise change count by +1 on push only and -1 on pop only; count never exceeds 2^DEPTH_LOG2 and never underflows.
REQ-024 SHALL NOT accept a push while full, even if a pop occurs in the same cycle.
REQ-025 SHALL set overflow on any cycle with in_valid && full && !flush; overflow stays set until flush or reset.
REQ-026 SHALL, on flush = 1, zero both pointers and count and clear overflow on the next edge; a concurrent push or pop is ignored.
REQ-027 SHALL present bytes at out_data in exact push order, with no loss or duplication.
REQ-028 SHALL tolerate out_ready dropping the cycle after a pop (transmitter leaves idle); no further pop occurs until out_ready returns.

Reset
REQ-029 SHALL, while reset_n = 0, asynchronously force rd_ptr = 0, wr_ptr = 0, count = 0, and overflow = 0, giving empty = 1, full = 0, out_req = 0, and in_ready = 1 once flush = 0.
REQ-030 SHALL leave memory contents unreset; out_data is don't-care after reset until the first push.
REQ-031 SHALL, on reset asserted mid-operation, discard all stored bytes immediately, with no out_req pulse during or after reset.

Verification
REQ-032 Bench SHALL cover this scenario: reset, then push 0x55 with out_ready = 1 -> out_req = 1 the next cycle with out_data = 0x55, then popped; empty = 1 one cycle later.
REQ-033 Bench SHALL cover this scenario: DEPTH_LOG2 = 4 with out_ready = 0, push 16 bytes 0x00..0x0F -> full = 1, count = 16, in_ready = 0; a 17th push sets overflow = 1 and is not stored.
REQ-034 Bench SHALL cover this scenario: from full, release out_ready one cycle at a time -> out_data sequence 0x00..0x0F in order, crossing pointer wrap, and empty = 1 at the end.
REQ-035 Bench SHALL cover this scenario: count = 3 with simultaneous push and pop -> count stays 3, and byte order is preserved.
REQ-036 Bench SHALL cover this scenario: count = 5 and overflow = 1, assert flush together with in_valid -> next cycle count = 0, overflow = 0, out_req = 0, and the flushed-cycle byte is dropped.
REQ-037 Bench SHALL cover this scenario: assert reset_n = 0 asynchronously mid-stream between clock edges -> count = 0 and out_req = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between a producer and a UART transmitter.
// The head byte is offered with out_req; the transmitter takes it on any
// cycle where it reports out_ready. A pushed byte becomes visible one
// cycle after the push, because out_req is derived from the registered count.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [7:0]            out_data,
  output logic                  out_req,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int                 DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ZERO  = (DEPTH_LOG2+1)'(1'b0);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(1'b0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  overflow_r;
  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;

  // Status and handshake decode; flush blocks both sides so a flush cycle
  // can neither store nor hand out a byte.
  always_comb begin
    empty_s = (count_r == CNT_ZERO);
    full_s  = (count_r == DEPTH_CNT);
    if (flush) begin
      in_ready = 1'b0;
      out_req  = 1'b0;
    end else begin
      in_ready = !full_s;
      out_req  = !empty_s;
    end
    push_s = in_valid && in_ready;
    pop_s  = out_req && out_ready;
  end

  assign out_data = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign empty    = empty_s;
  assign full     = full_s;
  assign overflow = overflow_r;

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow: set by any offer that arrives while full, cleared by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r <= 1'b0;
    end else if (in_valid && full_s) begin
      overflow_r <= 1'b1;
    end
  end

endmodule
